// File: rtl/hit_pkg.sv
// -----------------------------------------------------------------------------
// hit_pkg
// Shared types and helpers for the multi-ball hit controller.
//   border_side_t : which wall a border pixel belongs to
//   state_t       : controller FSM states
//   HOLE_W        : width of a hole index
//   num_pairs()   : number of unordered ball pairs (triangular count)
//   pair_bit()    : flat bit position of pair (i,j), i<j, in the pair vector
//   sat_abs()     : absolute value clamped to the positive range of a w-bit
//                   signed number
// -----------------------------------------------------------------------------
package hit_pkg;

    localparam int HOLE_W = 3;

    typedef enum logic [1:0] {
        SIDE_TOP    = 2'd0,
        SIDE_BOTTOM = 2'd1,
        SIDE_LEFT   = 2'd2,
        SIDE_RIGHT  = 2'd3
    } border_side_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_RESOLVE = 1'b1
    } state_t;

    function automatic int num_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Row-major upper triangle: (0,1),(0,2)..(0,n-1),(1,2)..
    function automatic int pair_bit(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // The most negative w-bit value has no positive twin, so it clamps.
    function automatic int sat_abs(input int v, input int w);
        int max_pos;
        max_pos = (1 << (w - 1)) - 1;
        if (v >= 0) return v;
        if (v < -max_pos) return max_pos;
        return -v;
    endfunction

endpackage

// File: rtl/multi_ball_hit_controller_if.sv
// -----------------------------------------------------------------------------
// multi_ball_hit_controller_if
// Result stream from the hit controller to the ball-motion blocks.
//   resValid/resReady : valid/ready handshake of one result beat
//   resIdx            : ball index of the beat
//   resVelX/resVelY   : resolved signed velocity
//   resCollision      : border or ball-ball event for this ball
//   resHoleHit        : ball entered a hole; resHoleNum is its index
//   frameDone         : last beat of the frame accepted
//   frameOverrun      : frame boundary arrived while still resolving
// master = controller side, slave = consumer side.
// -----------------------------------------------------------------------------
interface multi_ball_hit_controller_if
    import hit_pkg::*;
#(
    parameter int NUM_BALLS = 2,
    parameter int VEL_W     = 11
);
    localparam int IDX_W = $clog2(NUM_BALLS);

    logic              resValid;
    logic              resReady;
    logic [IDX_W-1:0]  resIdx;
    logic [VEL_W-1:0]  resVelX;
    logic [VEL_W-1:0]  resVelY;
    logic              resCollision;
    logic              resHoleHit;
    logic [HOLE_W-1:0] resHoleNum;
    logic              frameDone;
    logic              frameOverrun;

    modport master (
        output resValid, resIdx, resVelX, resVelY, resCollision,
               resHoleHit, resHoleNum, frameDone, frameOverrun,
        input  resReady
    );

    modport slave (
        input  resValid, resIdx, resVelX, resVelY, resCollision,
               resHoleHit, resHoleNum, frameDone, frameOverrun,
        output resReady
    );

endinterface

// File: rtl/hit_collector.sv
// -----------------------------------------------------------------------------
// hit_collector
// Sticky per-frame event collectors plus their start-of-frame snapshot.
//   clk, resetN      : clock, asynchronous active-low reset
//   clear_i          : restart collection (same-cycle events are kept)
//   snap_i           : copy current collector contents into the snapshot
//   ballDR_i ...     : pixel drawing requests and border side / hole index
//   snap_*_o         : snapshot of border, pair, hole and first hole number
// -----------------------------------------------------------------------------
module hit_collector
    import hit_pkg::*;
#(
    parameter int NUM_BALLS = 2
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              clear_i,
    input  logic                              snap_i,
    input  logic [NUM_BALLS-1:0]              ballDR_i,
    input  logic                              bordersDR_i,
    input  logic [1:0]                        borderSide_i,
    input  logic                              holesDR_i,
    input  logic [HOLE_W-1:0]                 holeNumber_i,
    output logic [NUM_BALLS-1:0][3:0]         snap_border_o,
    output logic [num_pairs(NUM_BALLS)-1:0]   snap_pair_o,
    output logic [NUM_BALLS-1:0]              snap_hole_o,
    output logic [NUM_BALLS-1:0][HOLE_W-1:0]  snap_hole_num_o
);
    localparam int NPAIRS = num_pairs(NUM_BALLS);

    logic [NUM_BALLS-1:0][3:0]        border_q, border_d, snap_border_q;
    logic [NPAIRS-1:0]                pair_q, pair_d, snap_pair_q;
    logic [NUM_BALLS-1:0]             hole_q, hole_d, snap_hole_q;
    logic [NUM_BALLS-1:0][HOLE_W-1:0] hole_num_q, hole_num_d, snap_hole_num_q;

    // NOTE: every variable gets its base value before any conditional update,
    // otherwise a path that skips the assignment would infer a latch.
    always_comb begin
        border_d   = clear_i ? '0 : border_q;
        pair_d     = clear_i ? '0 : pair_q;
        hole_d     = clear_i ? '0 : hole_q;
        hole_num_d = clear_i ? '0 : hole_num_q;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (ballDR_i[i] && bordersDR_i) border_d[i][borderSide_i] = 1'b1;
            // First hole of the frame wins; later holes leave the number alone.
            if (ballDR_i[i] && holesDR_i && !hole_d[i]) begin
                hole_d[i]     = 1'b1;
                hole_num_d[i] = holeNumber_i;
            end
            for (int j = i + 1; j < NUM_BALLS; j++) begin
                if (ballDR_i[i] && ballDR_i[j]) pair_d[pair_bit(i, j, NUM_BALLS)] = 1'b1;
            end
        end
    end

    // NOTE: these are plain flop banks, not RAM, so they all take the reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            border_q        <= '0;
            pair_q          <= '0;
            hole_q          <= '0;
            hole_num_q      <= '0;
            snap_border_q   <= '0;
            snap_pair_q     <= '0;
            snap_hole_q     <= '0;
            snap_hole_num_q <= '0;
        end else begin
            border_q   <= border_d;
            pair_q     <= pair_d;
            hole_q     <= hole_d;
            hole_num_q <= hole_num_d;
            if (snap_i) begin
                snap_border_q   <= border_q;
                snap_pair_q     <= pair_q;
                snap_hole_q     <= hole_q;
                snap_hole_num_q <= hole_num_q;
            end
        end
    end

    assign snap_border_o   = snap_border_q;
    assign snap_pair_o     = snap_pair_q;
    assign snap_hole_o     = snap_hole_q;
    assign snap_hole_num_o = snap_hole_num_q;

endmodule

// File: rtl/multi_ball_hit_controller.sv
// -----------------------------------------------------------------------------
// multi_ball_hit_controller
// Collects overlap events over a frame, snapshots them at startOfFrame and
// emits one resolved velocity/collision beat per ball on the result stream.
//   clk, resetN          : clock, asynchronous active-low reset
//   startOfFrame         : frame boundary pulse
//   ballDR, bordersDR,
//   borderSide, holesDR,
//   holeNumber           : current pixel drawing requests
//   ballVelX, ballVelY   : packed signed velocities, ball i at [i*VEL_W +: VEL_W]
//   res                  : result stream (master side)
// -----------------------------------------------------------------------------
module multi_ball_hit_controller
    import hit_pkg::*;
#(
    parameter int NUM_BALLS = 2,
    parameter int VEL_W     = 11
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_BALLS-1:0]       ballDR,
    input  logic                       bordersDR,
    input  logic [1:0]                 borderSide,
    input  logic                       holesDR,
    input  logic [HOLE_W-1:0]          holeNumber,
    input  logic [NUM_BALLS*VEL_W-1:0] ballVelX,
    input  logic [NUM_BALLS*VEL_W-1:0] ballVelY,
    multi_ball_hit_controller_if.master res
);
    localparam int IDX_W  = $clog2(NUM_BALLS);
    localparam int NPAIRS = num_pairs(NUM_BALLS);
    localparam logic [IDX_W:0]   BEATS    = (IDX_W + 1)'(NUM_BALLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    state_t                           state_q, state_d;
    logic [IDX_W:0]                   cnt_q, cnt_d;
    logic [NUM_BALLS-1:0][VEL_W-1:0]  vel_x_q, vel_y_q;
    logic                             valid_q, valid_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [VEL_W-1:0]                 vx_q, vx_d, vy_q, vy_d;
    logic                             coll_q, coll_d, hit_q, hit_d;
    logic [HOLE_W-1:0]                hnum_q, hnum_d;

    logic                             capture, load, last_accept;
    logic [IDX_W-1:0]                 cur;
    logic [NUM_BALLS-1:0][3:0]        snap_border;
    logic [NPAIRS-1:0]                snap_pair;
    logic [NUM_BALLS-1:0]             snap_hole;
    logic [NUM_BALLS-1:0][HOLE_W-1:0] snap_hole_num;
    logic [NUM_BALLS-1:0][VEL_W-1:0]  res_vx, res_vy;
    logic [NUM_BALLS-1:0]             res_coll;

    hit_collector #(.NUM_BALLS(NUM_BALLS)) u_collector (
        .clk             (clk),
        .resetN          (resetN),
        .clear_i         (capture),
        .snap_i          (capture),
        .ballDR_i        (ballDR),
        .bordersDR_i     (bordersDR),
        .borderSide_i    (borderSide),
        .holesDR_i       (holesDR),
        .holeNumber_i    (holeNumber),
        .snap_border_o   (snap_border),
        .snap_pair_o     (snap_pair),
        .snap_hole_o     (snap_hole),
        .snap_hole_num_o (snap_hole_num)
    );

    // Resolve every ball from the snapshot; the FSM picks one per beat.
    always_comb begin
        logic                    found;
        logic signed [VEL_W-1:0] vx, vy;
        int                      pb;
        res_vx   = '0;
        res_vy   = '0;
        res_coll = '0;
        found    = 1'b0;
        vx       = '0;
        vy       = '0;
        pb       = 0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            found       = 1'b0;
            vx          = $signed(vel_x_q[i]);
            vy          = $signed(vel_y_q[i]);
            res_coll[i] = |snap_border[i];
            // Ball-ball: take the velocity of the lowest-index partner.
            for (int j = 0; j < NUM_BALLS; j++) begin
                if (j < i)      pb = pair_bit(j, i, NUM_BALLS);
                else if (j > i) pb = pair_bit(i, j, NUM_BALLS);
                else            pb = 0;
                if (j != i && !found && snap_pair[pb]) begin
                    found       = 1'b1;
                    vx          = $signed(vel_x_q[j]);
                    vy          = $signed(vel_y_q[j]);
                    res_coll[i] = 1'b1;
                end
            end
            // Positive rule is applied last so it wins on opposite walls.
            if (snap_border[i][SIDE_BOTTOM]) vy = VEL_W'(-sat_abs(int'(vy), VEL_W));
            if (snap_border[i][SIDE_TOP])    vy = VEL_W'(sat_abs(int'(vy), VEL_W));
            if (snap_border[i][SIDE_RIGHT])  vx = VEL_W'(-sat_abs(int'(vx), VEL_W));
            if (snap_border[i][SIDE_LEFT])   vx = VEL_W'(sat_abs(int'(vx), VEL_W));
            if (snap_hole[i]) begin
                vx          = '0;
                vy          = '0;
                res_coll[i] = 1'b0;
            end
            res_vx[i] = vx;
            res_vy[i] = vy;
        end
    end

    assign cur         = cnt_q[IDX_W-1:0];
    assign load        = !valid_q || res.resReady;
    assign last_accept = (state_q == ST_RESOLVE) && valid_q && res.resReady && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        valid_d = valid_q;
        idx_d   = idx_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        coll_d  = coll_q;
        hit_d   = hit_q;
        hnum_d  = hnum_q;
        case (state_q)
            ST_COLLECT: begin
                if (startOfFrame) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (load) begin
                    if (cnt_q < BEATS) begin
                        valid_d = 1'b1;
                        idx_d   = cur;
                        vx_d    = res_vx[cur];
                        vy_d    = res_vy[cur];
                        coll_d  = res_coll[cur];
                        hit_d   = snap_hole[cur];
                        hnum_d  = snap_hole_num[cur];
                        cnt_d   = cnt_q + (IDX_W + 1)'(1);
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                if (last_accept) state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            vel_x_q <= '0;
            vel_y_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            coll_q  <= 1'b0;
            hit_q   <= 1'b0;
            hnum_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                vel_x_q <= ballVelX;
                vel_y_q <= ballVelY;
            end
            valid_q <= valid_d;
            idx_q   <= idx_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            coll_q  <= coll_d;
            hit_q   <= hit_d;
            hnum_q  <= hnum_d;
        end
    end

    assign res.resValid     = valid_q;
    assign res.resIdx       = idx_q;
    assign res.resVelX      = vx_q;
    assign res.resVelY      = vy_q;
    assign res.resCollision = coll_q;
    assign res.resHoleHit   = hit_q;
    assign res.resHoleNum   = hnum_q;
    assign res.frameDone    = last_accept;
    assign res.frameOverrun = (state_q == ST_RESOLVE) && startOfFrame;

endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// -----------------------------------------------------------------------------
// tb_multi_ball_hit_controller
// Self-checking bench for a three-ball controller. Each scenario drives pixel
// events and pushes the hand-derived beats it expects; beats are popped and
// compared as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_multi_ball_hit_controller;
    import hit_pkg::*;

    localparam int NB = 3;
    localparam int VW = 11;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              startOfFrame = 1'b0;
    logic [NB-1:0]     ballDR = '0;
    logic              bordersDR = 1'b0;
    logic [1:0]        borderSide = '0;
    logic              holesDR = 1'b0;
    logic [2:0]        holeNumber = '0;
    logic [NB*VW-1:0]  ballVelX = '0;
    logic [NB*VW-1:0]  ballVelY = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int idx; int vx; int vy; int coll; int hit; int hnum;
    } beat_t;
    beat_t sb[$];

    multi_ball_hit_controller_if #(.NUM_BALLS(NB), .VEL_W(VW)) res_bus ();

    multi_ball_hit_controller #(.NUM_BALLS(NB), .VEL_W(VW)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .ballDR       (ballDR),
        .bordersDR    (bordersDR),
        .borderSide   (borderSide),
        .holesDR      (holesDR),
        .holeNumber   (holeNumber),
        .ballVelX     (ballVelX),
        .ballVelY     (ballVelY),
        .res          (res_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic beat_t sample_beat();
        beat_t b;
        b.idx  = int'(res_bus.resIdx);
        b.vx   = int'($signed(res_bus.resVelX));
        b.vy   = int'($signed(res_bus.resVelY));
        b.coll = int'(res_bus.resCollision);
        b.hit  = int'(res_bus.resHoleHit);
        b.hnum = int'(res_bus.resHoleNum);
        return b;
    endfunction

    function automatic bit same_beat(input beat_t a, input beat_t e);
        return a.idx == e.idx && a.vx == e.vx && a.vy == e.vy &&
               a.coll == e.coll && a.hit == e.hit && a.hnum == e.hnum;
    endfunction

    task automatic set_vel(input int i, input int x, input int y);
        ballVelX[i*VW +: VW] = VW'(x);
        ballVelY[i*VW +: VW] = VW'(y);
    endtask

    task automatic expect_beat(input int idx, input int vx, input int vy,
                               input int coll, input int hit, input int hnum);
        beat_t b;
        b.idx = idx; b.vx = vx; b.vy = vy; b.coll = coll; b.hit = hit; b.hnum = hnum;
        sb.push_back(b);
    endtask

    task automatic drive_cycle(input logic sof, input logic [NB-1:0] mask, input logic brd,
                               input logic [1:0] side, input logic hole, input logic [2:0] hnum);
        startOfFrame = sof; ballDR = mask; bordersDR = brd; borderSide = side;
        holesDR = hole; holeNumber = hnum;
        @(posedge clk); #1;
        startOfFrame = 1'b0; ballDR = '0; bordersDR = 1'b0; holesDR = 1'b0; holeNumber = '0;
    endtask

    // Call right after the startOfFrame cycle. Beat k is due on cycle 2+k,
    // plus stall_cycles once the stalled beat is reached.
    task automatic run_frame(input string name, input int stall_beat,
                             input int stall_cycles, input int ovr_cyc);
        int    cyc = 0;
        int    beats = 0;
        int    stalled = 0;
        int    exp_cyc;
        beat_t a, e;
        res_bus.resReady = 1'b1;
        while (beats < NB && cyc < 60) begin
            @(negedge clk);
            cyc++;
            startOfFrame = (cyc == ovr_cyc);
            if (cyc == ovr_cyc) begin
                ballDR = 3'b100; bordersDR = 1'b1; borderSide = SIDE_TOP;
            end else begin
                ballDR = '0; bordersDR = 1'b0;
            end
            res_bus.resReady = !(res_bus.resValid && beats == stall_beat && stalled < stall_cycles);
            #1;
            vectors++;
            if (res_bus.frameOverrun !== (cyc == ovr_cyc)) begin
                miscompares++;
                $display("FAIL %s overrun cyc%0d: got %b want %b", name, cyc,
                         res_bus.frameOverrun, (cyc == ovr_cyc));
            end
            if (res_bus.resValid) begin
                a = sample_beat();
                if (sb.size() == 0) begin
                    vectors++; miscompares++; beats++;
                    $display("FAIL %s extra beat: got idx=%0d, none expected", name, a.idx);
                end else if (!res_bus.resReady) begin
                    stalled++;
                    vectors++;
                    if (!same_beat(a, sb[0])) begin
                        miscompares++;
                        $display("FAIL %s stall hold cyc%0d: got idx=%0d v=(%0d,%0d) want idx=%0d v=(%0d,%0d)",
                                 name, cyc, a.idx, a.vx, a.vy, sb[0].idx, sb[0].vx, sb[0].vy);
                    end
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (!same_beat(a, e)) begin
                        miscompares++;
                        $display("FAIL %s beat: got idx=%0d v=(%0d,%0d) c=%0d h=%0d n=%0d want idx=%0d v=(%0d,%0d) c=%0d h=%0d n=%0d",
                                 name, a.idx, a.vx, a.vy, a.coll, a.hit, a.hnum,
                                 e.idx, e.vx, e.vy, e.coll, e.hit, e.hnum);
                    end
                    exp_cyc = 2 + beats + ((beats >= stall_beat) ? stall_cycles : 0);
                    vectors++;
                    if (cyc != exp_cyc) begin
                        miscompares++;
                        $display("FAIL %s timing beat%0d: got cycle %0d want %0d", name, beats, cyc, exp_cyc);
                    end
                    beats++;
                    vectors++;
                    if (res_bus.frameDone !== (beats == NB)) begin
                        miscompares++;
                        $display("FAIL %s frameDone at beat%0d: got %b want %b", name, beats - 1,
                                 res_bus.frameDone, (beats == NB));
                    end
                end
            end else begin
                vectors++;
                if (res_bus.frameDone !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s spurious frameDone cyc%0d: got 1 want 0", name, cyc);
                end
            end
        end
        if (beats < NB) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, beats, NB);
        end
        startOfFrame = 1'b0; ballDR = '0; bordersDR = 1'b0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({res_bus.resValid, res_bus.resIdx, res_bus.resVelX, res_bus.resVelY,
             res_bus.resCollision, res_bus.resHoleHit, res_bus.resHoleNum,
             res_bus.frameDone, res_bus.frameOverrun} !== '0) begin
            miscompares++;
            $display("FAIL %s outputs: got v=%b i=%0d x=%h y=%h c=%b h=%b n=%0d d=%b o=%b want all 0",
                     name, res_bus.resValid, res_bus.resIdx, res_bus.resVelX, res_bus.resVelY,
                     res_bus.resCollision, res_bus.resHoleHit, res_bus.resHoleNum,
                     res_bus.frameDone, res_bus.frameOverrun);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        res_bus.resReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_border();
        set_vel(0, 5, 7); set_vel(1, -3, 2); set_vel(2, 9, -9);
        drive_cycle(1'b0, 3'b001, 1'b1, SIDE_RIGHT, 1'b0, 3'd0);
        drive_cycle(1'b0, 3'b000, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        expect_beat(0, -5, 7, 1, 0, 0);
        expect_beat(1, -3, 2, 0, 0, 0);
        expect_beat(2, 9, -9, 0, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("border", -1, 0, 0);
    endtask

    task automatic test_pair();
        set_vel(0, 3, 0); set_vel(1, -2, 1); set_vel(2, 4, 4);
        drive_cycle(1'b0, 3'b011, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        expect_beat(0, -2, 1, 1, 0, 0);
        expect_beat(1, 3, 0, 1, 0, 0);
        expect_beat(2, 4, 4, 0, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("pair", -1, 0, 0);
        // All three overlap: each ball takes its lowest-index partner.
        set_vel(0, 1, 2); set_vel(1, 3, 4); set_vel(2, 5, 6);
        drive_cycle(1'b0, 3'b111, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        expect_beat(0, 3, 4, 1, 0, 0);
        expect_beat(1, 1, 2, 1, 0, 0);
        expect_beat(2, 1, 2, 1, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("triple", -1, 0, 0);
    endtask

    task automatic test_hole();
        set_vel(0, -6, 2); set_vel(1, 7, -7); set_vel(2, 4, 8);
        drive_cycle(1'b0, 3'b001, 1'b1, SIDE_LEFT, 1'b0, 3'd0);
        drive_cycle(1'b0, 3'b100, 1'b1, SIDE_BOTTOM, 1'b0, 3'd0);
        drive_cycle(1'b0, 3'b010, 1'b0, SIDE_TOP, 1'b1, 3'd4);
        drive_cycle(1'b0, 3'b010, 1'b0, SIDE_TOP, 1'b1, 3'd2);
        drive_cycle(1'b0, 3'b010, 1'b1, SIDE_TOP, 1'b0, 3'd0);
        expect_beat(0, 6, 2, 1, 0, 0);
        expect_beat(1, 0, 0, 0, 1, 4);
        expect_beat(2, 4, -8, 1, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("hole", -1, 0, 0);
    endtask

    task automatic test_saturation();
        set_vel(0, 3, -1024); set_vel(1, -1024, 5); set_vel(2, -7, -1);
        drive_cycle(1'b0, 3'b001, 1'b1, SIDE_TOP, 1'b0, 3'd0);
        drive_cycle(1'b0, 3'b010, 1'b1, SIDE_RIGHT, 1'b0, 3'd0);
        drive_cycle(1'b0, 3'b100, 1'b1, SIDE_LEFT, 1'b0, 3'd0);
        drive_cycle(1'b0, 3'b100, 1'b1, SIDE_RIGHT, 1'b0, 3'd0);
        expect_beat(0, 3, 1023, 1, 0, 0);
        expect_beat(1, -1023, 5, 1, 0, 0);
        expect_beat(2, 7, -1, 1, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("saturation", -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        set_vel(0, 10, 11); set_vel(1, 12, 13); set_vel(2, 14, -3);
        drive_cycle(1'b0, 3'b001, 1'b1, SIDE_BOTTOM, 1'b0, 3'd0);
        expect_beat(0, 10, -11, 1, 0, 0);
        expect_beat(1, 12, 13, 0, 0, 0);
        expect_beat(2, 14, -3, 0, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        // Stall beat 0 for 3 cycles; overrun + ball 2 top event on cycle 3.
        run_frame("stall", 0, 3, 3);
        // Ball 2 event from the overrun cycle lands here; ball 0 event on the
        // boundary cycle belongs to the following frame.
        expect_beat(0, 10, 11, 0, 0, 0);
        expect_beat(1, 12, 13, 0, 0, 0);
        expect_beat(2, 14, 3, 1, 0, 0);
        drive_cycle(1'b1, 3'b001, 1'b1, SIDE_RIGHT, 1'b0, 3'd0);
        run_frame("carry", -1, 0, 0);
        expect_beat(0, -10, 11, 1, 0, 0);
        expect_beat(1, 12, 13, 0, 0, 0);
        expect_beat(2, 14, -3, 0, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("boundary", -1, 0, 0);
    endtask

    task automatic test_reset_mid();
        set_vel(0, 1, 1); set_vel(1, 2, 2); set_vel(2, 3, 3);
        drive_cycle(1'b0, 3'b011, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        res_bus.resReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (!(res_bus.resValid === 1'b1 && res_bus.resIdx === 2'd0)) begin
            miscompares++;
            $display("FAIL abort beat0: got valid=%b idx=%0d want valid=1 idx=0",
                     res_bus.resValid, res_bus.resIdx);
        end
        @(negedge clk);
        res_bus.resReady = 1'b0;
        vectors++;
        if (!(res_bus.resValid === 1'b1 && res_bus.resIdx === 2'd1)) begin
            miscompares++;
            $display("FAIL abort beat1: got valid=%b idx=%0d want valid=1 idx=1",
                     res_bus.resValid, res_bus.resIdx);
        end
        resetN = 1'b0;
        #1;
        check_zero("abort");
        res_bus.resReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (res_bus.frameDone !== 1'b0 || res_bus.resValid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort hold%0d: got done=%b valid=%b want 0 0", k,
                         res_bus.frameDone, res_bus.resValid);
            end
        end
        resetN = 1'b1;
        @(posedge clk); #1;
        // Reset cleared the collected pair event: velocities pass through.
        set_vel(0, 4, -4); set_vel(1, -5, 5); set_vel(2, 6, 0);
        expect_beat(0, 4, -4, 0, 0, 0);
        expect_beat(1, -5, 5, 0, 0, 0);
        expect_beat(2, 6, 0, 0, 0, 0);
        drive_cycle(1'b1, '0, 1'b0, SIDE_TOP, 1'b0, 3'd0);
        run_frame("after_abort", -1, 0, 0);
    endtask

    initial begin
        res_bus.resReady = 1'b0;
        test_reset();
        test_border();
        test_pair();
        test_hole();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
